// File: rtl/ixu_wb_pkg.sv
// Shared types and widths for the integer writeback path.
package ixu_wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/ixu_wb_queue.sv
// Multi-push / multi-pop circular writeback queue; occupancy tracked by count,
// so pointer equality never has to distinguish full from empty.
module ixu_wb_queue
  import ixu_wb_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int NUM_PUSH = 4,
  parameter int NUM_POP  = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int PW = $clog2(NUM_PUSH) + 1,
  localparam int OW = $clog2(NUM_POP) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PW-1:0]             push_cnt,
  input  wb_entry_t [NUM_PUSH-1:0]  push_data,
  input  logic [OW-1:0]             pop_cnt,
  output wb_entry_t [NUM_POP-1:0]   head_data,
  output logic [CW-1:0]             count
);

  wb_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_comb begin
    head_d  = head_q + AW'(pop_cnt);
    tail_d  = tail_q + AW'(push_cnt);
    count_d = count_q + CW'(push_cnt) - CW'(pop_cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (i < int'(push_cnt)) mem_q[tail_q + AW'(i)] <= push_data[i];
    end
  end

  for (genvar gi = 0; gi < NUM_POP; gi++) begin : g_head
    assign head_data[gi] = mem_q[head_q + AW'(gi)];
  end

  assign count = count_q;

endmodule

// File: rtl/ixu_writeback_multi.sv
// Multi-lane integer writeback: compacts surviving lanes into a FIFO and drains
// it onto the register-file write ports. IXU_WB_BYPASS_EN adds an empty-queue bypass.
module ixu_writeback_multi
  import ixu_wb_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int NUM_WPORTS = 2,
  parameter int DEPTH      = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_LANES-1:0]             is_nop,
  input  logic [NUM_LANES*REG_ADDR_W-1:0]  rd,
  input  logic [NUM_LANES*XLEN-1:0]        data_in,
  output logic [NUM_WPORTS*REG_ADDR_W-1:0] rd_out,
  output logic [NUM_WPORTS*XLEN-1:0]       data_out,
  output logic [NUM_WPORTS-1:0]            wr_en,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(NUM_LANES) + 1;
  localparam int OW = $clog2(NUM_WPORTS) + 1;

  logic                         accept;
  logic [NUM_LANES-1:0]         lane_keep;
  int                           lane_pos [NUM_LANES];
  int                           n_surv;
  int                           n_drain;
  int                           n_byp;
  wb_entry_t [NUM_LANES-1:0]    comp;
  wb_entry_t [NUM_LANES-1:0]    push_data;
  wb_entry_t [NUM_WPORTS-1:0]   head_data;
  wb_entry_t [NUM_WPORTS-1:0]   port_ent;
  logic [NUM_WPORTS-1:0]        port_vld;
  logic [PW-1:0]                push_cnt;
  logic [OW-1:0]                pop_cnt;

  assign in_ready = (count <= CW'(DEPTH - NUM_LANES));
  assign accept   = in_valid & in_ready & ~rst;

  // Each surviving lane lands in the slot given by how many survivors precede it.
  always_comb begin
    n_surv = 0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_keep[l] = ~is_nop[l] && (rd[l*REG_ADDR_W +: REG_ADDR_W] != '0);
      lane_pos[l]  = n_surv;
      if (lane_keep[l]) n_surv = n_surv + 1;
    end
    comp = '0;
    for (int o = 0; o < NUM_LANES; o++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (lane_keep[l] && lane_pos[l] == o) begin
          comp[o].rd   = rd[l*REG_ADDR_W +: REG_ADDR_W];
          comp[o].data = data_in[l*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    n_drain = (int'(count) < NUM_WPORTS) ? int'(count) : NUM_WPORTS;
    n_byp   = 0;
`ifdef IXU_WB_BYPASS_EN
    if (accept && count == '0) n_byp = (n_surv < NUM_WPORTS) ? n_surv : NUM_WPORTS;
`endif
    port_vld = '0;
    port_ent = '0;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      if (p < n_drain) begin
        port_vld[p] = 1'b1;
        port_ent[p] = head_data[p];
      end else if (p < n_byp) begin
        port_vld[p] = 1'b1;
        port_ent[p] = comp[p];
      end
    end
    // Bypassed survivors are skipped; the rest shift down to the tail.
    push_data = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int s = 0; s < NUM_LANES; s++) begin
        if (s == l + n_byp) push_data[l] = comp[s];
      end
    end
    push_cnt = accept ? PW'(n_surv - n_byp) : '0;
    pop_cnt  = OW'(n_drain);
  end

  ixu_wb_queue #(
    .DEPTH    (DEPTH),
    .NUM_PUSH (NUM_LANES),
    .NUM_POP  (NUM_WPORTS)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .head_data (head_data),
    .count     (count)
  );

  // A younger port writing the same register wins; older ones are suppressed.
  for (genvar gi = 0; gi < NUM_WPORTS; gi++) begin : g_port
    logic younger_hit;
    always_comb begin
      younger_hit = 1'b0;
      for (int q = gi + 1; q < NUM_WPORTS; q++) begin
        if (port_vld[q] && port_ent[q].rd == port_ent[gi].rd) younger_hit = 1'b1;
      end
    end
    assign wr_en[gi]                              = port_vld[gi] & ~younger_hit;
    assign rd_out[gi*REG_ADDR_W +: REG_ADDR_W]    = port_ent[gi].rd;
    assign data_out[gi*XLEN +: XLEN]              = port_ent[gi].data;
  end

endmodule

// File: tb/tb_ixu_writeback_multi.sv
// Directed bench for ixu_writeback_multi with the default 4-lane / 2-port / 8-deep configuration.
module tb_ixu_writeback_multi;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   is_nop = '0;
  logic [19:0]  rd = '0;
  logic [127:0] data_in = '0;
  logic [9:0]   rd_out;
  logic [63:0]  data_out;
  logic [1:0]   wr_en;
  logic [3:0]   count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ixu_writeback_multi #(.NUM_LANES(4), .NUM_WPORTS(2), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .is_nop   (is_nop),
    .rd       (rd),
    .data_in  (data_in),
    .rd_out   (rd_out),
    .data_out (data_out),
    .wr_en    (wr_en),
    .count    (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, "_rd_out"}, 64'(rd_out), 64'd0);
    chk({tag, "_data_out"}, data_out, 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    logic         v;
    logic [3:0]   nop;
    logic [19:0]  rd;
    logic [127:0] data;
    logic [3:0]   e_cnt;
    logic         e_rdy;
    logic [1:0]   e_wr;
    logic [9:0]   e_rd;
    logic [63:0]  e_data;
  } vec_t;

  vec_t vt [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 4'b0010, {5'd4, 5'd3, 5'd2, 5'd1}, {32'hD, 32'hC, 32'h2, 32'hA},
               4'd0, 1'b1, 2'b00, 10'd0, 64'd0};
    vt[1]  = '{1'b0, 4'b0000, 20'd0, 128'd0,
               4'd3, 1'b1, 2'b11, {5'd3, 5'd1}, {32'hC, 32'hA}};
    vt[2]  = '{1'b0, 4'b0000, 20'd0, 128'd0,
               4'd1, 1'b1, 2'b01, {5'd0, 5'd4}, {32'h0, 32'hD}};
    vt[3]  = '{1'b1, 4'b0011, {5'd0, 5'd0, 5'd8, 5'd7}, {4{32'hFFFF_FFFF}},
               4'd0, 1'b1, 2'b00, 10'd0, 64'd0};
    vt[4]  = '{1'b1, 4'b1100, {5'd7, 5'd7, 5'd5, 5'd5}, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2, 32'h1},
               4'd0, 1'b1, 2'b00, 10'd0, 64'd0};
    vt[5]  = '{1'b0, 4'b0000, 20'd0, 128'd0,
               4'd2, 1'b1, 2'b10, {5'd5, 5'd5}, {32'h2, 32'h1}};
    vt[6]  = '{1'b1, 4'b0100, {5'd10, 5'd11, 5'd9, 5'd0}, {32'h1010, 32'h1111, 32'h99, 32'h5},
               4'd0, 1'b1, 2'b00, 10'd0, 64'd0};
    vt[7]  = '{1'b1, 4'b0000, {5'd15, 5'd14, 5'd13, 5'd12}, {32'h15, 32'h14, 32'h13, 32'h12},
               4'd2, 1'b1, 2'b11, {5'd10, 5'd9}, {32'h1010, 32'h99}};
    vt[8]  = '{1'b0, 4'b0000, 20'd0, 128'd0,
               4'd4, 1'b1, 2'b11, {5'd13, 5'd12}, {32'h13, 32'h12}};
    vt[9]  = '{1'b0, 4'b0000, 20'd0, 128'd0,
               4'd2, 1'b1, 2'b11, {5'd15, 5'd14}, {32'h15, 32'h14}};
    vt[10] = '{1'b0, 4'b0000, 20'd0, 128'd0,
               4'd0, 1'b1, 2'b00, 10'd0, 64'd0};

    // Reset state, with a bundle offered that must never be taken.
    in_valid = 1'b1;
    is_nop   = 4'b0000;
    rd       = {5'd23, 5'd22, 5'd21, 5'd20};
    data_in  = {32'h23, 32'h22, 32'h21, 32'h20};
    #2;
    chk_idle("reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_idle("reset_held");
    rst      = 1'b0;
    in_valid = 1'b0;

`ifndef IXU_WB_BYPASS_EN
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = vt[i].v;
      is_nop   = vt[i].nop;
      rd       = vt[i].rd;
      data_in  = vt[i].data;
      #1;
      chk($sformatf("row%0d_count", i), 64'(count), 64'(vt[i].e_cnt));
      chk($sformatf("row%0d_in_ready", i), 64'(in_ready), 64'(vt[i].e_rdy));
      chk($sformatf("row%0d_wr_en", i), 64'(wr_en), 64'(vt[i].e_wr));
      chk($sformatf("row%0d_rd_out", i), 64'(rd_out), 64'(vt[i].e_rd));
      chk($sformatf("row%0d_data_out", i), data_out, vt[i].e_data);
      $display("[TB] row %0d valid=%b count=%0d wr_en=%b rd_out=%h", i, vt[i].v, count, wr_en, rd_out);
    end

    // Three full bundles back to back; a scoreboard follows all 12 writes.
    begin
      int wi = 0;
      int mcnt = 0;
      int b = 0;
      int drained;
      int mdrain;
      bit acc;
      for (int cyc = 0; cyc < 40 && wi < 12; cyc++) begin
        @(negedge clk);
        in_valid = (b < 3);
        is_nop   = 4'b0000;
        for (int l = 0; l < 4; l++) begin
          rd[l*5 +: 5]       = 5'(b*4 + l + 1);
          data_in[l*32 +: 32] = 32'((b*4 + l + 1) * 256);
        end
        #1;
        chk("bp_count", 64'(count), 64'(mcnt));
        chk("bp_in_ready", 64'(in_ready), 64'(mcnt <= 4));
        drained = 0;
        for (int p = 0; p < 2; p++) begin
          if (wr_en[p]) begin
            chk("bp_rd", 64'(rd_out[p*5 +: 5]), 64'(wi + 1));
            chk("bp_data", 64'(data_out[p*32 +: 32]), 64'((wi + 1) * 256));
            wi++;
            drained++;
          end
        end
        mdrain = (mcnt < 2) ? mcnt : 2;
        chk("bp_drained", 64'(drained), 64'(mdrain));
        acc  = (b < 3) && (mcnt <= 4);
        mcnt = mcnt + (acc ? 4 : 0) - mdrain;
        if (acc) b++;
        $display("[TB] bp cycle %0d count=%0d in_ready=%b wr_en=%b written=%0d", cyc, count, in_ready, wr_en, wi);
      end
      in_valid = 1'b0;
      chk("bp_all_written", 64'(wi), 64'd12);
      @(negedge clk);
      #1;
      chk("bp_final_count", 64'(count), 64'd0);
    end

    // Queue five entries, then reset mid-cycle.
    @(negedge clk);
    in_valid = 1'b1;
    is_nop   = 4'b0000;
    rd       = {5'd23, 5'd22, 5'd21, 5'd20};
    data_in  = {32'h23, 32'h22, 32'h21, 32'h20};
    @(negedge clk);
    is_nop   = 4'b1000;
    rd       = {5'd27, 5'd26, 5'd25, 5'd24};
    data_in  = {32'h27, 32'h26, 32'h25, 32'h24};
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("flush_pre_count", 64'(count), 64'd5);
    $display("[TB] flush: queued count=%0d", count);
    #2;
    rst      = 1'b1;
    in_valid = 1'b1;
    is_nop   = 4'b0000;
    rd       = {5'd23, 5'd22, 5'd21, 5'd20};
    #1;
    chk_idle("flush_during");
    @(posedge clk);
    @(negedge clk);
    chk_idle("flush_held");
    rst      = 1'b0;
    rd       = {5'd4, 5'd3, 5'd2, 5'd1};
    data_in  = {32'h44, 32'h33, 32'h22, 32'h11};
    #1;
    chk("flush_release_count", 64'(count), 64'd0);
    chk("flush_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("first_accept_count", 64'(count), 64'd4);
    chk("first_accept_wr_en", 64'(wr_en), 64'd3);
    chk("first_accept_rd_out", 64'(rd_out), 64'({5'd2, 5'd1}));
    chk("first_accept_data", data_out, {32'h22, 32'h11});
    $display("[TB] first accept after reset: count=%0d rd_out=%h", count, rd_out);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("first_accept_drained", 64'(count), 64'd0);
`else
    // Empty-queue bypass: two survivors go straight out, one is queued.
    @(negedge clk);
    in_valid = 1'b1;
    is_nop   = 4'b1000;
    rd       = {5'd9, 5'd7, 5'd6, 5'd2};
    data_in  = {32'h99, 32'd11, 32'd9, 32'd7};
    #1;
    chk("byp_wr_en", 64'(wr_en), 64'd3);
    chk("byp_rd_out", 64'(rd_out), 64'({5'd6, 5'd2}));
    chk("byp_data", data_out, {32'd9, 32'd7});
    chk("byp_count0", 64'(count), 64'd0);
    $display("[TB] bypass cycle: wr_en=%b rd_out=%h", wr_en, rd_out);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("byp_count1", 64'(count), 64'd1);
    chk("byp_next_wr_en", 64'(wr_en), 64'd1);
    chk("byp_next_rd_out", 64'(rd_out), 64'({5'd0, 5'd7}));
    chk("byp_next_data", data_out, {32'd0, 32'd11});
    $display("[TB] bypass follow-up: count=%0d rd_out=%h", count, rd_out);
    // Bypassed same-register pair still obeys the collision rule.
    @(negedge clk);
    in_valid = 1'b1;
    is_nop   = 4'b1100;
    rd       = {5'd1, 5'd1, 5'd5, 5'd5};
    data_in  = {32'd0, 32'd0, 32'd2, 32'd1};
    #1;
    chk("byp_coll_wr_en", 64'(wr_en), 64'd2);
    chk("byp_coll_data", data_out, {32'd2, 32'd1});
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("byp_coll_count", 64'(count), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
